// File: rtl/preset_pkg.sv
// Shared types and helpers for the preset save/recall sequencer.
package preset_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_WR,
    LOAD_RD,
    LOAD_WAIT,
    LOAD_SEND,
    FIN
  } state_e;

  // Flat RAM address of byte idx within a preset slot.
  function automatic int unsigned slot_addr(int unsigned slot, int unsigned idx,
                                            int unsigned plen);
    return slot * plen + idx;
  endfunction

endpackage

// File: rtl/preset_capture.sv
// Keeps the last PRESET_LEN RX bytes (newest at the top index) and a saturating count.
module preset_capture
  import preset_pkg::*;
#(
  parameter int PRESET_LEN = 4,
  parameter int CNT_W      = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rx_valid_i,
  input  logic [BYTE_W-1:0]                    rx_data_i,
  input  logic                                 enable_i,
  input  logic                                 clear_i,
  output logic [PRESET_LEN-1:0][BYTE_W-1:0]    bytes_o,
  output logic [CNT_W-1:0]                     cap_cnt_o
);

  logic [PRESET_LEN-1:0][BYTE_W-1:0] buf_q;
  logic [CNT_W-1:0]                  cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && rx_valid_i) begin
      buf_q <= {rx_data_i, buf_q[PRESET_LEN-1:1]};
      if (cnt_q != CNT_W'(PRESET_LEN)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bytes_o   = buf_q;
  assign cap_cnt_o = cnt_q;

endmodule

// File: rtl/preset_ctrl.sv
// Preset save/recall sequencer: captured RX bytes -> RAM slot, RAM slot -> TX stream.
module preset_ctrl
  import preset_pkg::*;
#(
  parameter  int SLOTS      = 2,
  parameter  int PRESET_LEN = 4,
  localparam int ADDR_W     = $clog2(SLOTS * PRESET_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        btn_index,
  input  logic              save_mode,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              req_dropped,
  output logic [SLOTS-1:0]  slot_valid
);

  localparam int CNT_W  = $clog2(PRESET_LEN + 1);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int BI_W   = (PRESET_LEN > 1) ? $clog2(PRESET_LEN) : 1;

  state_e                        state_q, state_d;
  logic [SLOT_W-1:0]             slot_q, slot_d;
  logic [CNT_W-1:0]              idx_q, idx_d;
  logic [SLOTS-1:0][CNT_W-1:0]   slot_len_q, slot_len_d;
  logic [BYTE_W-1:0]             tx_data_q, tx_data_d;
  logic                          req_dropped_q;
  logic [SLOTS-1:0]              slot_valid_q;

  logic [PRESET_LEN-1:0][BYTE_W-1:0] cap_bytes;
  logic [CNT_W-1:0]                  cap_cnt;
  logic                              cap_en, cap_clr;
  logic                              req_v;
  logic [CNT_W-1:0]                  wpos;

  // Buttons 1..SLOTS map to slots 0..SLOTS-1; anything else is not a request.
  assign req_v  = (btn_index != 2'd0) && (int'({30'b0, btn_index}) <= SLOTS);
  assign cap_en = (state_q == IDLE) || (state_q == LOAD_RD) ||
                  (state_q == LOAD_WAIT) || (state_q == LOAD_SEND);

  preset_capture #(
    .PRESET_LEN (PRESET_LEN),
    .CNT_W      (CNT_W)
  ) u_cap (
    .clk        (clk),
    .rst        (rst),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .enable_i   (cap_en),
    .clear_i    (cap_clr),
    .bytes_o    (cap_bytes),
    .cap_cnt_o  (cap_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    idx_d      = idx_q;
    slot_len_d = slot_len_q;
    tx_data_d  = tx_data_q;
    cap_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_v) begin
          slot_d = SLOT_W'(btn_index - 2'd1);
          idx_d  = '0;
          if (save_mode) begin
            // An empty capture buffer turns a save into a slot clear.
            if (cap_cnt == '0) begin
              slot_len_d[slot_d] = '0;
              state_d            = FIN;
            end else begin
              state_d = SAVE_WR;
            end
          end else begin
            state_d = (slot_len_q[slot_d] != '0) ? LOAD_RD : FIN;
          end
        end
      end
      SAVE_WR: begin
        if (idx_q + CNT_W'(1) == cap_cnt) begin
          slot_len_d[slot_q] = cap_cnt;
          cap_clr            = 1'b1;
          state_d            = FIN;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      LOAD_RD:   state_d = LOAD_WAIT;
      LOAD_WAIT: begin
        tx_data_d = mem_rdata;
        state_d   = LOAD_SEND;
      end
      LOAD_SEND: begin
        if (tx_ready) begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = (idx_d == slot_len_q[slot_q]) ? FIN : LOAD_RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q        <= '0;
      idx_q         <= '0;
      slot_len_q    <= '0;
      tx_data_q     <= '0;
      req_dropped_q <= 1'b0;
      slot_valid_q  <= '0;
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      slot_len_q    <= slot_len_d;
      tx_data_q     <= tx_data_d;
      req_dropped_q <= req_v && (state_q != IDLE);
      for (int s = 0; s < SLOTS; s++) slot_valid_q[s] <= (slot_len_d[s] != '0);
    end
  end

  // Oldest captured byte sits cap_cnt entries below the top of the buffer.
  assign wpos = CNT_W'(PRESET_LEN) - cap_cnt + idx_q;

  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == FIN);
    mem_we      = (state_q == SAVE_WR);
    mem_re      = (state_q == LOAD_RD);
    mem_addr    = '0;
    mem_wdata   = '0;
    tx_valid    = (state_q == LOAD_SEND);
    tx_data     = tx_data_q;
    req_dropped = req_dropped_q;
    slot_valid  = slot_valid_q;
    if (mem_we || mem_re)
      mem_addr = ADDR_W'(slot_addr(32'(slot_q), 32'(idx_q), PRESET_LEN));
    if (mem_we)
      mem_wdata = cap_bytes[BI_W'(wpos)];
  end

endmodule

// File: tb/tb_preset_ctrl.sv
// Randomised + directed bench for preset_ctrl against a transaction-level reference model.
module tb_preset_ctrl;
  localparam int SLOTS = 2;
  localparam int PL    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_index;
  logic       save_mode, rx_valid, tx_ready;
  logic [7:0] rx_data, mem_wdata, mem_rdata, tx_data;
  logic       mem_we, mem_re, tx_valid, busy, done, req_dropped;
  logic [2:0] mem_addr;
  logic [SLOTS-1:0] slot_valid;

  preset_ctrl #(.SLOTS(SLOTS), .PRESET_LEN(PL)) dut (
    .clk(clk), .rst(rst), .btn_index(btn_index), .save_mode(save_mode),
    .rx_valid(rx_valid), .rx_data(rx_data), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy),
    .done(done), .req_dropped(req_dropped), .slot_valid(slot_valid)
  );

  always #5 clk = ~clk;

  // Synchronous preset RAM, read data one cycle after mem_re.
  logic [7:0] ram [8];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Reference model: each accepted request expands into a queue of per-cycle
  // expected actions; a send entry lingers until the sink accepts it.
  typedef enum int {K_W, K_R, K_WT, K_S, K_F} kind_e;
  typedef struct { kind_e kind; int addr; logic [7:0] data; bit last; } rec_t;
  typedef logic [7:0] bq_t[$];

  rec_t sched[$];
  bq_t  cap;
  bq_t  presets [SLOTS];
  bq_t  pdata;
  int   pslot;
  bit   drop_exp;

  int n_chk = 0, n_pass = 0;
  int hs_n, we_n, done_n, txv_n, drop_n;
  logic [7:0] hs_q[$];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    sched.delete();
    cap.delete();
    for (int s = 0; s < SLOTS; s++) presets[s].delete();
    drop_exp = 1'b0;
  endtask

  function automatic logic [SLOTS-1:0] exp_sv();
    logic [SLOTS-1:0] r;
    for (int s = 0; s < SLOTS; s++) r[s] = (presets[s].size() != 0);
    return r;
  endfunction

  task automatic model_step();
    bit    was_idle, cap_on;
    kind_e k;
    int    s;
    was_idle = (sched.size() == 0);
    k        = was_idle ? K_F : sched[0].kind;
    cap_on   = was_idle || k == K_R || k == K_WT || k == K_S;
    if (!was_idle && !(k == K_S && !tx_ready)) begin
      if (k == K_W && sched[0].last) presets[pslot] = pdata;
      void'(sched.pop_front());
    end
    drop_exp = 1'b0;
    if (rx_valid && cap_on) begin
      cap.push_back(rx_data);
      if (cap.size() > PL) void'(cap.pop_front());
    end
    if (btn_index == 2'd1 || btn_index == 2'd2) begin
      s = int'(btn_index) - 1;
      if (!was_idle) drop_exp = 1'b1;
      else if (save_mode) begin
        if (cap.size() == 0) presets[s].delete();
        else begin
          pslot = s;
          pdata = cap;
          for (int i = 0; i < cap.size(); i++)
            sched.push_back('{K_W, s * PL + i, cap[i], bit'(i == cap.size() - 1)});
          cap.delete();
        end
        sched.push_back('{K_F, 0, 8'h00, 1'b0});
      end else begin
        for (int i = 0; i < presets[s].size(); i++) begin
          sched.push_back('{K_R, s * PL + i, 8'h00, 1'b0});
          sched.push_back('{K_WT, 0, 8'h00, 1'b0});
          sched.push_back('{K_S, 0, presets[s][i], 1'b0});
        end
        sched.push_back('{K_F, 0, 8'h00, 1'b0});
      end
    end
  endtask

  task automatic compare();
    rec_t h;
    bit   act;
    act = (sched.size() != 0);
    if (act) h = sched[0];
    check("busy", busy, act);
    check("done", done, act && h.kind == K_F);
    check("mem_we", mem_we, act && h.kind == K_W);
    check("mem_re", mem_re, act && h.kind == K_R);
    check("tx_valid", tx_valid, act && h.kind == K_S);
    if (act && (h.kind == K_W || h.kind == K_R)) check("mem_addr", mem_addr, h.addr);
    if (act && h.kind == K_W) check("mem_wdata", mem_wdata, h.data);
    if (act && h.kind == K_S) check("tx_data", tx_data, h.data);
    check("req_dropped", req_dropped, drop_exp);
    check("slot_valid", slot_valid, exp_sv());
  endtask

  task automatic drive(input logic [1:0] b, input logic sm, input logic rv,
                       input logic [7:0] rd, input logic rdy);
    btn_index = b; save_mode = sm; rx_valid = rv; rx_data = rd; tx_ready = rdy;
  endtask

  task automatic tick();
    if (tx_valid && tx_ready) begin hs_n++; hs_q.push_back(tx_data); end
    if (mem_we)      we_n++;
    if (done)        done_n++;
    if (tx_valid)    txv_n++;
    if (req_dropped) drop_n++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin drive(2'd0, 1'b0, 1'b0, 8'h00, rdy); tick(); end
  endtask

  task automatic clr();
    hs_n = 0; we_n = 0; done_n = 0; txv_n = 0; drop_n = 0; hs_q.delete();
  endtask

  task automatic do_reset();
    drive(2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [1:0] rb;
  logic       rv;
  int         w;

  initial begin
    drive(2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 0);
    check("rst_drop", req_dropped, 0);
    check("rst_sv", slot_valid, 0);
    rst = 1'b0;

    // Recall of an empty slot right after reset.
    clr();
    drive(2'd2, 1'b0, 1'b0, 8'h00, 1'b1); tick();
    idle(2, 1'b1);
    check("empty_recall_done", done_n, 1);
    check("empty_recall_txv", txv_n, 0);

    // Capture two bytes then save to slot 1.
    clr();
    drive(2'd0, 1'b0, 1'b1, 8'hC0, 1'b0); tick();
    drive(2'd0, 1'b0, 1'b1, 8'h05, 1'b0); tick();
    drive(2'd1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    idle(4, 1'b0);
    check("save_ram0", ram[0], 8'hC0);
    check("save_ram1", ram[1], 8'h05);
    check("save_we_n", we_n, 2);
    check("save_done", done_n, 1);
    check("save_sv", slot_valid, 2'b01);

    // Recall with the sink stalled for a while.
    clr();
    drive(2'd1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    idle(7, 1'b0);
    idle(8, 1'b1);
    check("recall_hs_n", hs_n, 2);
    check("recall_b0", (hs_q.size() > 0) ? hs_q[0] : 8'hXX, 8'hC0);
    check("recall_b1", (hs_q.size() > 1) ? hs_q[1] : 8'hXX, 8'h05);
    check("recall_done", done_n, 1);

    // Request arriving mid-recall is dropped.
    clr();
    drive(2'd1, 1'b0, 1'b0, 8'h00, 1'b1); tick();
    drive(2'd2, 1'b0, 1'b0, 8'h00, 1'b1); tick();
    idle(10, 1'b1);
    check("drop_n", drop_n, 1);
    check("drop_hs_n", hs_n, 2);
    check("drop_done", done_n, 1);

    // Overflow: six bytes, last four land in slot 2.
    clr();
    for (int i = 1; i <= 6; i++) begin drive(2'd0, 1'b0, 1'b1, 8'(i), 1'b0); tick(); end
    drive(2'd2, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    idle(6, 1'b0);
    check("ovf_ram4", ram[4], 8'h03);
    check("ovf_ram5", ram[5], 8'h04);
    check("ovf_ram6", ram[6], 8'h05);
    check("ovf_ram7", ram[7], 8'h06);
    check("ovf_we_n", we_n, 4);
    check("ovf_sv", slot_valid, 2'b11);

    // Save with nothing captured clears slot 1.
    clr();
    drive(2'd1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    idle(3, 1'b0);
    check("clear_we_n", we_n, 0);
    check("clear_done", done_n, 1);
    check("clear_sv", slot_valid, 2'b10);

    // Byte arriving during the write burst is not captured.
    clr();
    drive(2'd0, 1'b0, 1'b1, 8'h33, 1'b0); tick();
    drive(2'd1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    drive(2'd0, 1'b0, 1'b1, 8'h44, 1'b0); tick();
    idle(3, 1'b1);
    drive(2'd1, 1'b0, 1'b0, 8'h00, 1'b1); tick();
    idle(8, 1'b1);
    check("swr_rx_hs_n", hs_n, 1);
    check("swr_rx_b0", (hs_q.size() > 0) ? hs_q[0] : 8'hXX, 8'h33);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rb = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rv = (rb == 2'd0) && ($urandom_range(0, 2) == 0);
      drive(rb, 1'($urandom_range(0, 1)), rv, 8'($urandom), ($urandom_range(0, 3) != 0));
      tick();
    end

    // Reset while a byte is being offered.
    do_reset();
    drive(2'd0, 1'b0, 1'b1, 8'h55, 1'b0); tick();
    drive(2'd1, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    idle(3, 1'b0);
    drive(2'd1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    w = 0;
    while (!tx_valid && w < 10) begin idle(1, 1'b0); w++; end
    check("mid_txv_seen", tx_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_txv", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b0);
    check("mid_rst_sv", slot_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/preset_ctrl.md
Name: preset_ctrl

Overview:
- Sequences preset save and recall for the MIDI footswitch. Sits between the button front end (btn_index/save_mode pulses), the MIDI RX byte stream, a synchronous preset RAM and the MIDI TX byte sink.
- Save: the most recent captured RX bytes are written to the RAM slot of the pressed button.
- Recall: the stored bytes are replayed to TX through a valid/ready handshake.

Parameters:
- SLOTS, 2: number of preset slots; slot = btn_index-1.
- PRESET_LEN, 4: max bytes per preset.
- ADDR_W (localparam), $clog2(SLOTS*PRESET_LEN): RAM address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- btn_index  in  2  one-cycle request; 0 = none, 1/2 = button, 3 = ignored
- save_mode  in  1  qualifies btn_index; 1 = save, 0 = recall
- rx_valid  in  1  RX byte strobe
- rx_data  in  8  RX byte
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable
- mem_addr  out  ADDR_W  slot*PRESET_LEN + byte index
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid 1 cycle after mem_re
- tx_valid  out  1  TX byte valid
- tx_data  out  8  TX byte
- tx_ready  in  1  TX accepts byte
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse when a save or recall finishes
- req_dropped  out  1  one-cycle pulse when a request is ignored because busy
- slot_valid  out  SLOTS  bit s = slot s holds a non-empty preset

Behaviour:
- Reset (async, rst=1): FSM = IDLE. All outputs 0. Capture buffer is cleared (cap_cnt=0). slot_len[] = 0. RAM contents are untouched but treated as empty.
- Capture:
  - Shift buffer of the last PRESET_LEN RX bytes.
  - cap_cnt increments on each rx_valid and saturates at PRESET_LEN.
  - Capture is active only in IDLE and LOAD_*. RX bytes arriving during SAVE_WR are dropped.
- Request decode: only sampled in IDLE. btn_index in {1,2} with slot < SLOTS is a request. The slot is latched on the sampling edge.
- Request while busy: no effect on the FSM; req_dropped pulses next cycle.
- States:
  - IDLE: on a save request, go to SAVE_WR (idx=0). If cap_cnt==0, skip directly to FIN and set slot_len=0, which clears the slot. On a recall request, go to LOAD_RD if slot_len>0; otherwise go to FIN with no TX output.
  - SAVE_WR: one write per cycle, oldest captured byte first. mem_we=1, mem_addr=slot*PRESET_LEN+idx. After cap_cnt writes: slot_len[slot] <= cap_cnt, cap_cnt <= 0, go to FIN.
  - LOAD_RD: mem_re=1 at addr slot*PRESET_LEN+idx, go to LOAD_WAIT.
  - LOAD_WAIT: register mem_rdata into tx_data, go to LOAD_SEND.
  - LOAD_SEND: tx_valid=1. tx_data is held stable until tx_ready. On the handshake: idx++; if idx==slot_len go to FIN, else go to LOAD_RD.
  - FIN: done=1 for one cycle, then IDLE.
- Throughput: recall is at most 1 byte per 3 cycles. Save is 1 byte/cycle plus FIN.
- Latency:
  - Recall request sampled at edge N → mem_re high in cycle N+1 → tx_valid high from cycle N+3.
  - Save of k bytes: mem_we high in cycles N+1..N+k, done in cycle N+k+1.
- tx_valid never deasserts without a handshake, except on reset.
- Reset mid-operation aborts the operation immediately. No done pulse. A save in progress leaves slot_len at 0 for all slots.
- slot_valid[s] = (slot_len[s] != 0), registered.

Decomposition:
- Package preset_pkg holds: the state enum (IDLE, SAVE_WR, LOAD_RD, LOAD_WAIT, LOAD_SEND, FIN), the BYTE_W=8 constant, and a slot_addr(slot, idx) function.
- Sub-module preset_capture holds the shift buffer and saturating cap_cnt. Inputs: rx_valid, rx_data, enable, clear. Outputs: the byte array and cap_cnt.

Test Plan:
- Capture then save: RX 0xC0, 0x05, then btn_index=1 with save_mode=1 → writes addr0=0xC0, addr1=0x05 in two consecutive cycles. done pulses. slot_valid=2'b01.
- Recall with backpressure: after the save above, btn_index=1 with save_mode=0, tx_ready held low 5 cycles then high → tx_data=0xC0 stable while waiting, then 0x05 follows. Exactly 2 handshakes, then done.
- Overflow: RX 6 bytes 0x01..0x06, save to slot 2 → addr 4..7 receive 0x03, 0x04, 0x05, 0x06. slot_len=4.
- Empty cases: recall slot 2 after reset → done within 2 cycles, tx_valid never high. Save with cap_cnt=0 into a valid slot → slot cleared, no mem_we.
- Busy drop: btn_index=2 pulse during a recall → req_dropped pulses once, recall completes unchanged. RX byte during SAVE_WR is not captured.
- Reset mid-recall: assert rst while tx_valid=1 → tx_valid, busy and done drop asynchronously. slot_valid=0 after release.
